// File: rtl/frame_sender_pkg.sv
// -----------------------------------------------------------------------------
// frame_sender_pkg
// Definitions shared by the serial start-pattern link transmitter
// (frame_sender) and the matching receive-side detector.
//   state_e    : frame FSM states, IDLE -> START -> SYNC -> DATA -> PAR -> GAP
//   LINE_*     : line levels for the fixed framing bits
//   cnt_width(): bits needed to hold a counter terminal value (minimum 1)
// -----------------------------------------------------------------------------
package frame_sender_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StStart = 3'd1,
      StSync  = 3'd2,
      StData  = 3'd3,
      StPar   = 3'd4,
      StGap   = 3'd5
   } state_e;

   localparam logic LINE_IDLE  = 1'b1;
   localparam logic LINE_START = 1'b0;
   localparam logic LINE_SYNC  = 1'b1;

   // Width of a counter that must reach max_val; never narrower than one bit
   // so that degenerate parameter choices still produce a legal vector.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val > 0) ? $clog2(max_val + 1) : 1;
   endfunction

endpackage

// File: rtl/frame_shift_reg.sv
// -----------------------------------------------------------------------------
// frame_shift_reg
// Payload holding register for frame_sender. Loads a parallel word, shifts it
// left one place per enabled cycle and presents the current MSB. The even
// parity of the loaded word is captured at load time so it survives shifting.
// Ports:
//   clock    : rising-edge clock
//   reset    : synchronous active-high reset, clears word and parity
//   i_load   : capture i_data (and its parity)
//   i_data   : word to capture
//   i_shift  : shift the held word left by one, zero fill
//   o_msb    : current MSB of the held word
//   o_parity : XOR of the last loaded word (even parity bit)
// -----------------------------------------------------------------------------
module frame_shift_reg #(
   parameter int unsigned DATA_W = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_shift,
   output logic              o_msb,
   output logic              o_parity
);

   logic [DATA_W-1:0] r_shift;
   logic              r_parity;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_shift  <= '0;
         r_parity <= 1'b0;
      end else if (i_load) begin
         r_shift  <= i_data;
         r_parity <= ^i_data;
      end else if (i_shift) begin
         r_shift  <= r_shift << 1;
      end
   end

   assign o_msb    = r_shift[DATA_W-1];
   assign o_parity = r_parity;

endmodule

// File: rtl/frame_sender.sv
// -----------------------------------------------------------------------------
// frame_sender
// Transmit end of the serial start-pattern link. Accepts a word over a
// valid/ready handshake and sends it on a single wire as:
//   idle(1) | START(0) | SYNC(1) | DATA_W payload bits MSB first |
//   optional even-parity bit | GAP idle-high cycles
// Ports:
//   clock      : rising-edge clock
//   reset      : synchronous active-high reset; abandons any frame in flight
//   tx_valid   : producer has a word
//   tx_data    : word, sampled only on acceptance (tx_valid && tx_ready)
//   tx_ready   : high only while idle
//   x_out      : registered serial line
//   busy       : high from START through the last GAP cycle
//   frame_done : one-cycle pulse in the cycle after the last payload/parity bit
// -----------------------------------------------------------------------------
module frame_sender
   import frame_sender_pkg::*;
#(
   parameter int unsigned DATA_W    = 4,
   parameter int unsigned GAP       = 1,
   parameter int unsigned PARITY_EN = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   output logic              x_out,
   output logic              busy,
   output logic              frame_done
);

   localparam int unsigned BitW = cnt_width(DATA_W - 1);
   localparam int unsigned GapW = cnt_width(GAP);

   localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);
   localparam logic [GapW-1:0] GapLast = (GAP > 0) ? GapW'(GAP - 1) : '0;

   // State after the last payload/parity bit: straight back to idle when no
   // gap is configured.
   localparam state_e StAfterBits = (GAP > 0) ? StGap : StIdle;

   state_e          r_state;
   state_e          w_state_d;
   logic [BitW-1:0] r_bit_cnt;
   logic [BitW-1:0] w_bit_cnt_d;
   logic [GapW-1:0] r_gap_cnt;
   logic [GapW-1:0] w_gap_cnt_d;
   logic            r_x_out;
   logic            w_x_out_d;
   logic            r_frame_done;
   logic            w_frame_done_d;

   logic            w_load;
   logic            w_shift;
   logic            w_msb;
   logic            w_parity;

   frame_shift_reg #(
      .DATA_W (DATA_W)
   ) u_shift_reg (
      .clock    (clock),
      .reset    (reset),
      .i_load   (w_load),
      .i_data   (tx_data),
      .i_shift  (w_shift),
      .o_msb    (w_msb),
      .o_parity (w_parity)
   );

   // Next-state and counters.
   always_comb begin
      w_state_d      = r_state;
      w_bit_cnt_d    = r_bit_cnt;
      w_gap_cnt_d    = r_gap_cnt;
      w_load         = 1'b0;
      w_frame_done_d = 1'b0;

      unique case (r_state)
         StIdle: begin
            if (tx_valid) begin
               w_load    = 1'b1;
               w_state_d = StStart;
            end
         end

         StStart: begin
            w_state_d = StSync;
         end

         StSync: begin
            w_state_d   = StData;
            w_bit_cnt_d = '0;
         end

         StData: begin
            if (r_bit_cnt == BitLast) begin
               w_bit_cnt_d = '0;
               if (PARITY_EN != 0) begin
                  w_state_d = StPar;
               end else begin
                  w_state_d      = StAfterBits;
                  w_gap_cnt_d    = '0;
                  w_frame_done_d = 1'b1;
               end
            end else begin
               w_bit_cnt_d = r_bit_cnt + 1'b1;
            end
         end

         StPar: begin
            w_state_d      = StAfterBits;
            w_gap_cnt_d    = '0;
            w_frame_done_d = 1'b1;
         end

         StGap: begin
            if (r_gap_cnt == GapLast) begin
               w_state_d   = StIdle;
               w_gap_cnt_d = '0;
            end else begin
               w_gap_cnt_d = r_gap_cnt + 1'b1;
            end
         end

         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   // Line value for the cycle we are about to enter. Registering it against
   // the next state gives START in the cycle right after acceptance and keeps
   // the line free of decode glitches. The payload shifts on the same edge
   // that registers its MSB, so the next bit is ready one cycle later.
   always_comb begin
      w_x_out_d = LINE_IDLE;
      w_shift   = 1'b0;

      unique case (w_state_d)
         StStart: w_x_out_d = LINE_START;
         StSync:  w_x_out_d = LINE_SYNC;
         StData: begin
            w_x_out_d = w_msb;
            w_shift   = 1'b1;
         end
         StPar:   w_x_out_d = w_parity;
         default: w_x_out_d = LINE_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= StIdle;
         r_bit_cnt    <= '0;
         r_gap_cnt    <= '0;
         r_x_out      <= LINE_IDLE;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_bit_cnt    <= w_bit_cnt_d;
         r_gap_cnt    <= w_gap_cnt_d;
         r_x_out      <= w_x_out_d;
         r_frame_done <= w_frame_done_d;
      end
   end

   assign tx_ready   = (r_state == StIdle);
   assign busy       = (r_state != StIdle);
   assign x_out      = r_x_out;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_frame_sender.sv
// -----------------------------------------------------------------------------
// tb_frame_sender
// Bench for frame_sender: one instance with default parameters and one with
// even parity enabled. Fixed vectors, hand sequences for back-to-back frames
// and reset corner cases, then random traffic checked against a queue-based
// line model and a behavioural receiver.
// -----------------------------------------------------------------------------
module tb_frame_sender;

   logic       clock = 1'b0;
   logic       rst_d, rst_p;
   logic       valid_d, valid_p;
   logic [3:0] data_d, data_p;
   logic       rdy_d, x_d, busy_d, done_d;
   logic       rdy_p, x_p, busy_p, done_p;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   frame_sender #(
      .DATA_W    (4),
      .GAP       (1),
      .PARITY_EN (0)
   ) u_dut (
      .clock      (clock),
      .reset      (rst_d),
      .tx_valid   (valid_d),
      .tx_data    (data_d),
      .tx_ready   (rdy_d),
      .x_out      (x_d),
      .busy       (busy_d),
      .frame_done (done_d)
   );

   frame_sender #(
      .DATA_W    (4),
      .GAP       (1),
      .PARITY_EN (1)
   ) u_dut_par (
      .clock      (clock),
      .reset      (rst_p),
      .tx_valid   (valid_p),
      .tx_data    (data_p),
      .tx_ready   (rdy_p),
      .x_out      (x_p),
      .busy       (busy_p),
      .frame_done (done_p)
   );

   typedef struct {
      bit         par;
      logic [3:0] data;
      int         len;      // cycles checked after acceptance, last one idle
      logic [8:0] exp_x;    // bit (len-i) = x_out in cycle i after acceptance
      logic [8:0] exp_done;
   } vec_t;

   typedef struct {
      logic x;
      logic done;
   } slot_t;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit par, input logic v, input logic [3:0] d, input logic r);
      if (par) begin
         valid_p = v;
         data_p  = d;
         rst_p   = r;
      end else begin
         valid_d = v;
         data_d  = d;
         rst_d   = r;
      end
   endtask

   task automatic sample(input bit par, output logic x, output logic b, output logic r,
                         output logic dn);
      x  = par ? x_p : x_d;
      b  = par ? busy_p : busy_d;
      r  = par ? rdy_p : rdy_d;
      dn = par ? done_p : done_d;
   endtask

   // One word with a single valid cycle; tx_data is scrambled during the frame.
   task automatic apply_vec(input int k, input vec_t v);
      logic x, b, r, dn;
      drive(v.par, 1'b1, v.data, 1'b0);
      step();
      for (int i = 1; i <= v.len; i++) begin
         drive(v.par, 1'b0, 4'($urandom), 1'b0);
         sample(v.par, x, b, r, dn);
         chk($sformatf("vec%0d_x_c%0d", k, i), 32'(x), 32'(v.exp_x[v.len-i]));
         chk($sformatf("vec%0d_done_c%0d", k, i), 32'(dn), 32'(v.exp_done[v.len-i]));
         chk($sformatf("vec%0d_rdy_c%0d", k, i), 32'(r), 32'(i == v.len));
         chk($sformatf("vec%0d_busy_c%0d", k, i), 32'(b), 32'(i != v.len));
         if (i < v.len) step();
      end
   endtask

   // Random traffic against a queue of expected line slots plus a receiver.
   task automatic run_random(input bit par);
      slot_t      q[$];
      slot_t      s;
      logic [3:0] sent[$];
      logic [3:0] det[$];
      bit         idle_now;
      bit         acc;
      int         acc_n;
      int         cyc;
      int         rx_phase;
      int         rx_n;
      int         rx_bad;
      logic [3:0] rx_word;
      logic       v;
      logic [3:0] d;
      logic       x, b, r, dn;

      acc_n    = 0;
      cyc      = 0;
      rx_phase = 0;
      rx_n     = 0;
      rx_bad   = 0;
      rx_word  = '0;
      drive(par, 1'b0, 4'h0, 1'b1);
      step();
      drive(par, 1'b0, 4'h0, 1'b0);
      idle_now = 1'b1;

      while (cyc < 3000 && !(acc_n >= 20 && q.size() == 0 && idle_now)) begin
         v = (acc_n < 20) && ($urandom_range(0, 2) != 0);
         d = 4'($urandom);
         drive(par, v, d, 1'b0);
         acc = v && idle_now;
         step();
         cyc++;
         if (acc) begin
            acc_n++;
            sent.push_back(d);
            s.done = 1'b0;
            s.x = 1'b0; q.push_back(s);
            s.x = 1'b1; q.push_back(s);
            for (int i = 3; i >= 0; i--) begin
               s.x = d[i];
               q.push_back(s);
            end
            if (par) begin
               s.x = ^d;
               q.push_back(s);
            end
            s.x = 1'b1; s.done = 1'b1; q.push_back(s);
         end
         if (q.size() > 0) begin
            s = q.pop_front();
            idle_now = 1'b0;
         end else begin
            s.x = 1'b1;
            s.done = 1'b0;
            idle_now = 1'b1;
         end
         sample(par, x, b, r, dn);
         chk($sformatf("rnd%0d_x_c%0d", par, cyc), 32'(x), 32'(s.x));
         chk($sformatf("rnd%0d_busy_c%0d", par, cyc), 32'(b), 32'(!idle_now));
         chk($sformatf("rnd%0d_rdy_c%0d", par, cyc), 32'(r), 32'(idle_now));
         chk($sformatf("rnd%0d_done_c%0d", par, cyc), 32'(dn), 32'(s.done));

         // Receiver: hunt for START, require SYNC, collect payload, check parity.
         case (rx_phase)
            0: if (x == 1'b0) rx_phase = 1;
            1: begin
               if (x == 1'b1) begin
                  rx_phase = 2;
                  rx_n     = 0;
                  rx_word  = '0;
               end else begin
                  rx_bad++;
                  rx_phase = 0;
               end
            end
            2: begin
               rx_word = {rx_word[2:0], x};
               rx_n++;
               if (rx_n == 4) begin
                  if (par) begin
                     rx_phase = 3;
                  end else begin
                     det.push_back(rx_word);
                     rx_phase = 0;
                  end
               end
            end
            default: begin
               if (x == ^rx_word) det.push_back(rx_word);
               else rx_bad++;
               rx_phase = 0;
            end
         endcase
      end
      drive(par, 1'b0, 4'h0, 1'b0);

      chk($sformatf("rnd%0d_sent", par), 32'(acc_n), 32'd20);
      chk($sformatf("rnd%0d_detected", par), 32'(det.size()), 32'(sent.size()));
      chk($sformatf("rnd%0d_rx_bad", par), 32'(rx_bad), 32'd0);
      for (int i = 0; i < sent.size() && i < det.size(); i++) begin
         chk($sformatf("rnd%0d_word%0d", par, i), 32'(det[i]), 32'(sent[i]));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vec_t vecs[8];
      logic x, b, r, dn;
      logic [15:0] exp16;
      logic [17:0] exp18;

      vecs[0] = '{par: 1'b0, data: 4'hB, len: 8, exp_x: 9'b0_01101111, exp_done: 9'b0_00000010};
      vecs[1] = '{par: 1'b0, data: 4'hA, len: 8, exp_x: 9'b0_01101011, exp_done: 9'b0_00000010};
      vecs[2] = '{par: 1'b0, data: 4'h5, len: 8, exp_x: 9'b0_01010111, exp_done: 9'b0_00000010};
      vecs[3] = '{par: 1'b0, data: 4'h0, len: 8, exp_x: 9'b0_01000011, exp_done: 9'b0_00000010};
      vecs[4] = '{par: 1'b0, data: 4'hF, len: 8, exp_x: 9'b0_01111111, exp_done: 9'b0_00000010};
      vecs[5] = '{par: 1'b0, data: 4'h1, len: 8, exp_x: 9'b0_01000111, exp_done: 9'b0_00000010};
      vecs[6] = '{par: 1'b1, data: 4'h7, len: 9, exp_x: 9'b010111111, exp_done: 9'b000000010};
      vecs[7] = '{par: 1'b1, data: 4'h3, len: 9, exp_x: 9'b010011011, exp_done: 9'b000000010};

      // Reset, then ten idle cycles.
      drive(1'b0, 1'b0, 4'h0, 1'b1);
      drive(1'b1, 1'b0, 4'h0, 1'b1);
      step();
      step();
      drive(1'b0, 1'b0, 4'h0, 1'b0);
      drive(1'b1, 1'b0, 4'h0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("idle_x_%0d", i), 32'(x_d), 32'd1);
         chk($sformatf("idle_rdy_%0d", i), 32'(rdy_d), 32'd1);
         chk($sformatf("idle_busy_%0d", i), 32'(busy_d), 32'd0);
         chk($sformatf("idle_done_%0d", i), 32'(done_d), 32'd0);
      end
      chk("idle_par_x", 32'(x_p), 32'd1);
      chk("idle_par_rdy", 32'(rdy_p), 32'd1);

      // Table vectors.
      for (int k = 0; k < 8; k++) apply_vec(k, vecs[k]);

      // Back-to-back with valid held: A then 5, data changed during frame 1.
      exp16 = 16'b01101011_01010111;
      drive(1'b0, 1'b1, 4'hA, 1'b0);
      step();
      for (int i = 1; i <= 16; i++) begin
         if (i == 1) drive(1'b0, 1'b1, 4'h5, 1'b0);
         if (i == 9) drive(1'b0, 1'b0, 4'h5, 1'b0);
         chk($sformatf("b2b_x_c%0d", i), 32'(x_d), 32'(exp16[16-i]));
         chk($sformatf("b2b_done_c%0d", i), 32'(done_d), 32'(i == 7 || i == 15));
         if (i < 16) step();
      end
      chk("b2b_rdy_end", 32'(rdy_d), 32'd1);

      // Parity instance, valid held: 0111 then 0011, period 9.
      exp18 = 18'b010111111_010011011;
      drive(1'b1, 1'b1, 4'h7, 1'b0);
      step();
      for (int i = 1; i <= 18; i++) begin
         if (i == 1) drive(1'b1, 1'b1, 4'h3, 1'b0);
         if (i == 10) drive(1'b1, 1'b0, 4'h3, 1'b0);
         chk($sformatf("pb2b_x_c%0d", i), 32'(x_p), 32'(exp18[18-i]));
         chk($sformatf("pb2b_rdy_c%0d", i), 32'(rdy_p), 32'(i == 9 || i == 18));
         if (i < 18) step();
      end

      // Reset during the second DATA cycle, then an immediate new word.
      drive(1'b0, 1'b1, 4'hF, 1'b0);
      step();
      drive(1'b0, 1'b0, 4'h0, 1'b0);
      step();
      step();
      step();
      chk("rst_pre_x", 32'(x_d), 32'd1);
      chk("rst_pre_busy", 32'(busy_d), 32'd1);
      drive(1'b0, 1'b0, 4'h0, 1'b1);
      step();
      chk("rst_x", 32'(x_d), 32'd1);
      chk("rst_rdy", 32'(rdy_d), 32'd1);
      chk("rst_busy", 32'(busy_d), 32'd0);
      chk("rst_done", 32'(done_d), 32'd0);
      drive(1'b0, 1'b1, 4'h0, 1'b0);
      step();
      drive(1'b0, 1'b0, 4'h0, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         sample(1'b0, x, b, r, dn);
         chk($sformatf("rst_new_x_c%0d", i), 32'(x), 32'(vecs[3].exp_x[8-i]));
         chk($sformatf("rst_new_done_c%0d", i), 32'(dn), 32'(i == 7));
         if (i < 8) step();
      end

      // Reset wins over acceptance in the same cycle.
      drive(1'b0, 1'b1, 4'h3, 1'b1);
      step();
      drive(1'b0, 1'b0, 4'h3, 1'b0);
      chk("rprio_rdy", 32'(rdy_d), 32'd1);
      chk("rprio_x", 32'(x_d), 32'd1);
      step();
      chk("rprio_x2", 32'(x_d), 32'd1);
      chk("rprio_busy2", 32'(busy_d), 32'd0);

      // Random traffic on both instances.
      run_random(1'b0);
      run_random(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
